// File: rtl/cache_data_ways.sv
// -----------------------------------------------------------------------------
// cache_data_ways
//   Multi-way cache data array with an internal refill engine.
//   Storage: WAYS ways x LINE lines x BLOCK 32-bit words, byte-writable,
//   read-first. Line contents are never reset.
//
//   The refill engine gathers BLOCK beats critical-word-first with wrap-around
//   into a line buffer. It then writes the whole line into one way in a single
//   COMMIT cycle.
//
// Ports
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   rd_en/rd_index         read all ways of one line; rdata/rd_valid 1 cycle later
//   rdata                  way w at bits [w*32*BLOCK +: 32*BLOCK]
//   st_*                   store-hit word write with byte strobes; st_ready in IDLE
//   rf_start/rf_way/
//   rf_index/rf_offset     start a refill (sampled only in IDLE)
//   rf_valid/rf_ready/
//   rf_data/rf_last        refill beat handshake; rf_last is only checked
//   rf_done/rf_err         one-cycle pulses in the commit cycle
//   busy                   refill engine not IDLE
// -----------------------------------------------------------------------------
module cache_data_ways #(
  parameter int WAYS  = 2,
  parameter int LINE  = 128,
  parameter int BLOCK = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  // read path
  input  logic                      rd_en,
  input  logic [$clog2(LINE)-1:0]   rd_index,
  output logic                      rd_valid,
  output logic [WAYS*32*BLOCK-1:0]  rdata,
  // store-hit path
  input  logic                      st_en,
  output logic                      st_ready,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] st_way,
  input  logic [$clog2(LINE)-1:0]   st_index,
  input  logic [$clog2(BLOCK)-1:0]  st_offset,
  input  logic [3:0]                st_wstrb,
  input  logic [31:0]               st_wdata,
  // refill path
  input  logic                      rf_start,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] rf_way,
  input  logic [$clog2(LINE)-1:0]   rf_index,
  input  logic [$clog2(BLOCK)-1:0]  rf_offset,
  input  logic                      rf_valid,
  output logic                      rf_ready,
  input  logic [31:0]               rf_data,
  input  logic                      rf_last,
  output logic                      rf_done,
  output logic                      rf_err,
  output logic                      busy
);

  localparam int IW = $clog2(LINE);
  localparam int OW = $clog2(BLOCK);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LW = 32 * BLOCK;  // bits per line
  localparam int BW = 4 * BLOCK;   // byte enables per line

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  // A single-way array has only one legal way select.
  function automatic logic [WW-1:0] way_sel(input logic [WW-1:0] way);
    if (WAYS == 1) begin
      return '0;
    end else begin
      return way;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic [OW-1:0]     cnt_q;
  logic              err_q;
  logic [WW-1:0]     fill_way_q;
  logic [IW-1:0]     fill_index_q;
  logic [OW-1:0]     fill_offset_q;
  logic              rf_ready_q;
  logic              rf_done_q;
  logic              rf_err_q;
  logic              busy_q;
  logic              st_ready_q;
  logic              rd_valid_q;
  logic [WAYS*LW-1:0] rdata_q;

  logic [31:0]       line_buf_q [BLOCK];
  logic [LW-1:0]     mem_q [WAYS][LINE];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              beat_acc_s;
  logic              last_beat_s;
  logic              beat_err_s;
  logic              err_d;
  logic [OW-1:0]     fill_slot_s;
  logic              st_acc_s;

  logic              wr_en_s;
  logic [WW-1:0]     wr_way_s;
  logic [IW-1:0]     wr_index_s;
  logic [LW-1:0]     wr_line_s;
  logic [BW-1:0]     wr_be_s;
  logic [LW-1:0]     buf_line_s;

  assign beat_acc_s  = (state_q == S_FILL) && rf_valid;
  assign last_beat_s = (cnt_q == OW'(BLOCK - 1));
  // rf_last must be set on the final beat and only there.
  assign beat_err_s  = rf_last ^ last_beat_s;
  assign err_d       = err_q | beat_err_s;
  // Offset arithmetic in OW bits gives the modulo-BLOCK wrap for free.
  assign fill_slot_s = fill_offset_q + cnt_q;
  assign st_acc_s    = st_en && (state_q == S_IDLE);

  // Flatten the line buffer into one line-wide write word.
  always_comb begin
    buf_line_s = '0;
    for (int i = 0; i < BLOCK; i++) begin
      buf_line_s[i*32 +: 32] = line_buf_q[i];
    end
  end

  // Single array write port: commit (full line) or store hit (masked word).
  // The two never coincide because stores are accepted only in IDLE.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_way_s   = '0;
    wr_index_s = '0;
    wr_line_s  = '0;
    wr_be_s    = '0;
    if (state_q == S_COMMIT) begin
      wr_en_s    = 1'b1;
      wr_way_s   = way_sel(fill_way_q);
      wr_index_s = fill_index_q;
      wr_line_s  = buf_line_s;
      wr_be_s    = {BW{1'b1}};
    end else if (st_acc_s && (st_wstrb != 4'b0000)) begin
      wr_en_s    = 1'b1;
      wr_way_s   = way_sel(st_way);
      wr_index_s = st_index;
      wr_line_s  = {BLOCK{st_wdata}};
      wr_be_s    = BW'(st_wstrb) << {st_offset, 2'b00};
    end else begin
      wr_en_s    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------

  // Data array byte-write port; contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < BW; b++) begin
        if (wr_be_s[b]) begin
          mem_q[wr_way_s][wr_index_s][b*8 +: 8] <= wr_line_s[b*8 +: 8];
        end
      end
    end
  end

  // Data array read port: all ways at once, read-first against the write port.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        rdata_q[w*LW +: LW] <= mem_q[w][rd_index];
      end
    end
  end

  // Line buffer fill: each accepted beat lands at its wrapped word slot.
  always_ff @(posedge clk) begin
    if (beat_acc_s) begin
      line_buf_q[fill_slot_s] <= rf_data;
    end
  end

  // Read-valid flag, one cycle after each accepted read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Refill FSM with registered handshake/status outputs
  // ---------------------------------------------------------------------------
  // A reset during FILL simply abandons the buffer: the array is only ever
  // written in COMMIT, so nothing partial can reach it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      fill_way_q    <= '0;
      fill_index_q  <= '0;
      fill_offset_q <= '0;
      rf_ready_q    <= 1'b0;
      rf_done_q     <= 1'b0;
      rf_err_q      <= 1'b0;
      busy_q        <= 1'b0;
      st_ready_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          rf_done_q <= 1'b0;
          rf_err_q  <= 1'b0;
          if (rf_start) begin
            state_q       <= S_FILL;
            fill_way_q    <= way_sel(rf_way);
            fill_index_q  <= rf_index;
            fill_offset_q <= rf_offset;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            rf_ready_q    <= 1'b1;
            busy_q        <= 1'b1;
            st_ready_q    <= 1'b0;
          end else begin
            state_q    <= S_IDLE;
            rf_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            st_ready_q <= 1'b1;
          end
        end
        S_FILL: begin
          if (beat_acc_s) begin
            cnt_q <= cnt_q + OW'(1);
            err_q <= err_d;
            if (last_beat_s) begin
              // The done/err pulses are raised here so they are visible
              // exactly during the COMMIT cycle.
              state_q    <= S_COMMIT;
              rf_ready_q <= 1'b0;
              rf_done_q  <= 1'b1;
              rf_err_q   <= err_d;
            end else begin
              state_q <= S_FILL;
            end
          end else begin
            state_q <= S_FILL;
          end
        end
        S_COMMIT: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          err_q      <= 1'b0;
          rf_ready_q <= 1'b0;
          rf_done_q  <= 1'b0;
          rf_err_q   <= 1'b0;
          busy_q     <= 1'b0;
          st_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          err_q      <= 1'b0;
          rf_ready_q <= 1'b0;
          rf_done_q  <= 1'b0;
          rf_err_q   <= 1'b0;
          busy_q     <= 1'b0;
          st_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign rd_valid = rd_valid_q;
  assign rdata    = rdata_q;
  assign st_ready = st_ready_q;
  assign rf_ready = rf_ready_q;
  assign rf_done  = rf_done_q;
  assign rf_err   = rf_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_cache_data_ways.sv
// -----------------------------------------------------------------------------
// tb_cache_data_ways
//   Self-checking bench for cache_data_ways. A transaction-level model keeps
//   the array contents (with a per-byte "known" mask, since the array is never
//   reset) and the refill as a queue of gathered beats. Directed scenarios are
//   followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_cache_data_ways;

  localparam int WAYS  = 2;
  localparam int LINE  = 128;
  localparam int BLOCK = 8;
  localparam int IW    = $clog2(LINE);
  localparam int OW    = $clog2(BLOCK);
  localparam int WW    = 1;

  logic                     clk;
  logic                     resetn;
  logic                     rd_en;
  logic [IW-1:0]            rd_index;
  logic                     rd_valid;
  logic [WAYS*32*BLOCK-1:0] rdata;
  logic                     st_en;
  logic                     st_ready;
  logic [WW-1:0]            st_way;
  logic [IW-1:0]            st_index;
  logic [OW-1:0]            st_offset;
  logic [3:0]               st_wstrb;
  logic [31:0]              st_wdata;
  logic                     rf_start;
  logic [WW-1:0]            rf_way;
  logic [IW-1:0]            rf_index;
  logic [OW-1:0]            rf_offset;
  logic                     rf_valid;
  logic                     rf_ready;
  logic [31:0]              rf_data;
  logic                     rf_last;
  logic                     rf_done;
  logic                     rf_err;
  logic                     busy;

  cache_data_ways #(.WAYS(WAYS), .LINE(LINE), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_en     (rd_en),
    .rd_index  (rd_index),
    .rd_valid  (rd_valid),
    .rdata     (rdata),
    .st_en     (st_en),
    .st_ready  (st_ready),
    .st_way    (st_way),
    .st_index  (st_index),
    .st_offset (st_offset),
    .st_wstrb  (st_wstrb),
    .st_wdata  (st_wdata),
    .rf_start  (rf_start),
    .rf_way    (rf_way),
    .rf_index  (rf_index),
    .rf_offset (rf_offset),
    .rf_valid  (rf_valid),
    .rf_ready  (rf_ready),
    .rf_data   (rf_data),
    .rf_last   (rf_last),
    .rf_done   (rf_done),
    .rf_err    (rf_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_data [WAYS][LINE][BLOCK];
  logic [31:0] m_mask [WAYS][LINE][BLOCK];
  bit          m_fill;
  bit          m_commit;
  bit          m_err;
  int          m_way;
  int          m_idx;
  int          m_off;
  logic [31:0] m_beats[$];

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_word(input int w, input int k);
    return rdata[(w*BLOCK + k)*32 +: 32];
  endfunction

  task automatic clr();
    rd_en = 1'b0; rd_index = '0;
    st_en = 1'b0; st_way = '0; st_index = '0; st_offset = '0; st_wstrb = 4'h0; st_wdata = 32'h0;
    rf_start = 1'b0; rf_way = '0; rf_index = '0; rf_offset = '0;
    rf_valid = 1'b0; rf_data = 32'h0; rf_last = 1'b0;
  endtask

  // Predict the effect of the coming clock edge from the current inputs,
  // advance one cycle, then compare every output against the model.
  task automatic tick();
    logic [31:0] ed [WAYS][BLOCK];
    logic [31:0] em [WAYS][BLOCK];
    bit          rd;
    rd = rd_en;
    for (int w = 0; w < WAYS; w++) begin
      for (int k = 0; k < BLOCK; k++) begin
        ed[w][k] = m_data[w][rd_index][k];
        em[w][k] = rd ? m_mask[w][rd_index][k] : 32'h0;
      end
    end
    if (m_commit) begin
      for (int k = 0; k < BLOCK; k++) begin
        m_data[m_way][m_idx][(m_off + k) % BLOCK] = m_beats[k];
        m_mask[m_way][m_idx][(m_off + k) % BLOCK] = 32'hFFFF_FFFF;
      end
      m_commit = 1'b0;
    end else if (m_fill) begin
      if (rf_valid) begin
        if (rf_last != (m_beats.size() == BLOCK - 1)) m_err = 1'b1;
        m_beats.push_back(rf_data);
        if (m_beats.size() == BLOCK) begin
          m_fill   = 1'b0;
          m_commit = 1'b1;
        end
      end
    end else begin
      if (st_en) begin
        for (int b = 0; b < 4; b++) begin
          if (st_wstrb[b]) begin
            m_data[st_way][st_index][st_offset][b*8 +: 8] = st_wdata[b*8 +: 8];
            m_mask[st_way][st_index][st_offset][b*8 +: 8] = 8'hFF;
          end
        end
      end
      if (rf_start) begin
        m_fill = 1'b1;
        m_way  = int'(rf_way);
        m_idx  = int'(rf_index);
        m_off  = int'(rf_offset);
        m_err  = 1'b0;
        m_beats.delete();
      end
    end
    @(posedge clk);
    #1;
    check_val("rd_valid", rd_valid, rd);
    if (rd) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int k = 0; k < BLOCK; k++) begin
          check_val($sformatf("rdata_w%0d_k%0d", w, k), dut_word(w, k) & em[w][k], ed[w][k] & em[w][k]);
        end
      end
    end
    check_val("busy",     busy,     m_fill || m_commit);
    check_val("st_ready", st_ready, !(m_fill || m_commit));
    check_val("rf_ready", rf_ready, m_fill);
    check_val("rf_done",  rf_done,  m_commit);
    check_val("rf_err",   rf_err,   m_commit && m_err);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must drop at once.
  task automatic reset_pulse();
    resetn = 1'b0;
    #1;
    m_fill   = 1'b0;
    m_commit = 1'b0;
    m_err    = 1'b0;
    m_beats.delete();
    check_val("rst_busy",     busy,     1'b0);
    check_val("rst_rf_ready", rf_ready, 1'b0);
    check_val("rst_rf_done",  rf_done,  1'b0);
    check_val("rst_rf_err",   rf_err,   1'b0);
    check_val("rst_st_ready", st_ready, 1'b1);
    check_val("rst_rd_valid", rd_valid, 1'b0);
    #1;
    resetn = 1'b1;
  endtask

  task automatic do_store(input int w, input int i, input int o, input logic [3:0] s, input logic [31:0] d);
    clr();
    st_en = 1'b1; st_way = WW'(w); st_index = IW'(i); st_offset = OW'(o); st_wstrb = s; st_wdata = d;
    tick();
    clr();
  endtask

  task automatic do_read(input int i);
    clr();
    rd_en = 1'b1; rd_index = IW'(i);
    tick();
    clr();
  endtask

  // Start a refill and feed n beats back-to-back; rf_last on beat last_at.
  // With poke set, a store to way1/idx5/word3 is attempted during beat 1.
  task automatic do_refill(input int w, input int i, input int o, input logic [31:0] base,
                           input int last_at, input int n, input bit poke);
    clr();
    rf_start = 1'b1; rf_way = WW'(w); rf_index = IW'(i); rf_offset = OW'(o);
    tick();
    clr();
    for (int b = 0; b < n; b++) begin
      rf_valid = 1'b1;
      rf_data  = base + 32'(b);
      rf_last  = (b == last_at);
      if (poke && b == 1) begin
        st_en = 1'b1; st_way = 1'b1; st_index = 7'd5; st_offset = 3'd3;
        st_wstrb = 4'hF; st_wdata = 32'hBAD0_BAD0;
      end else begin
        st_en = 1'b0;
      end
      tick();
    end
    clr();
  endtask

  initial begin
    for (int w = 0; w < WAYS; w++)
      for (int i = 0; i < LINE; i++)
        for (int k = 0; k < BLOCK; k++) begin
          m_data[w][i][k] = 32'h0;
          m_mask[w][i][k] = 32'h0;
        end
    m_fill = 1'b0; m_commit = 1'b0; m_err = 1'b0;
    clr();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_rd_valid", rd_valid, 1'b0);
    check_val("reset_busy",     busy,     1'b0);
    check_val("reset_st_ready", st_ready, 1'b1);
    check_val("reset_rf_ready", rf_ready, 1'b0);
    check_val("reset_rf_done",  rf_done,  1'b0);
    check_val("reset_rf_err",   rf_err,   1'b0);
    resetn = 1'b1;

    // 1: full store then read
    do_store(1, 5, 3, 4'b1111, 32'hDEAD_BEEF);
    do_read(5);
    check_val("t1_way1_w3", dut_word(1, 3), 32'hDEAD_BEEF);

    // 2: partial store merges with old bytes
    do_store(0, 2, 1, 4'b1111, 32'hAAAA_AAAA);
    do_store(0, 2, 1, 4'b0101, 32'h1122_3344);
    do_store(0, 2, 1, 4'b0000, 32'hFFFF_FFFF);
    do_read(2);
    check_val("t2_merge", dut_word(0, 1), 32'hAA22_AA44);

    // 3: wrapped refill, rf_done 8 cycles after the first beat
    do_refill(0, 7, 5, 32'h100, 7, 8, 1'b0);
    check_val("t3_done", rf_done, 1'b1);
    check_val("t3_err",  rf_err,  1'b0);
    tick();  // commit cycle
    check_val("t3_done_once", rf_done, 1'b0);
    do_read(7);
    check_val("t3_w5", dut_word(0, 5), 32'h100);
    check_val("t3_w0", dut_word(0, 0), 32'h103);
    check_val("t3_w4", dut_word(0, 4), 32'h107);

    // 4: early rf_last still commits after 8 beats with rf_err
    do_refill(1, 3, 0, 32'h200, 2, 8, 1'b0);
    check_val("t4_done", rf_done, 1'b1);
    check_val("t4_err",  rf_err,  1'b1);
    tick();
    do_read(3);
    check_val("t4_w7", dut_word(1, 7), 32'h207);

    // 5: read in the commit cycle sees the old line; store during FILL is refused
    do_refill(0, 7, 2, 32'h300, 7, 8, 1'b1);
    clr(); rd_en = 1'b1; rd_index = 7'd7;
    tick();  // commit cycle with read
    clr();
    check_val("t5_old_w5", dut_word(0, 5), 32'h100);
    do_read(7);
    check_val("t5_new_w2", dut_word(0, 2), 32'h300);
    do_read(5);
    check_val("t5_nostore", dut_word(1, 3), 32'hDEAD_BEEF);

    // 6: reset mid-refill leaves the line untouched
    do_refill(1, 9, 0, 32'h400, 7, 8, 1'b0);
    tick();
    do_refill(1, 9, 0, 32'h500, 7, 4, 1'b0);
    reset_pulse();
    tick();
    do_read(9);
    check_val("t6_prior_w0", dut_word(1, 0), 32'h400);
    check_val("t6_prior_w3", dut_word(1, 3), 32'h403);

    // randomized traffic on a small index window
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) reset_pulse();
      clr();
      rd_en     = ($urandom_range(0, 1) == 1);
      rd_index  = IW'($urandom_range(0, 15));
      st_en     = ($urandom_range(0, 9) < 3);
      st_way    = WW'($urandom_range(0, 1));
      st_index  = IW'($urandom_range(0, 15));
      st_offset = OW'($urandom_range(0, BLOCK - 1));
      st_wstrb  = 4'($urandom_range(0, 15));
      st_wdata  = $urandom;
      rf_start  = ($urandom_range(0, 19) == 0);
      rf_way    = WW'($urandom_range(0, 1));
      rf_index  = IW'($urandom_range(0, 15));
      rf_offset = OW'($urandom_range(0, BLOCK - 1));
      rf_valid  = ($urandom_range(0, 9) < 7);
      rf_data   = $urandom;
      if (m_fill && m_beats.size() == BLOCK - 1)
        rf_last = ($urandom_range(0, 9) != 0);
      else
        rf_last = ($urandom_range(0, 19) == 0);
      tick();
    end
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_data_ways.md
Name: cache_data_ways

Overview:
- Multi-way, parametrised cache data array; next generation of the single-way line RAM.
- Holds WAYS ways of LINE lines, each BLOCK 32-bit words.
- Adds an internal refill engine. It gathers a burst of BLOCK words, critical-word-first with wrap-around, into a line buffer, then commits the whole line into one way in one write.
- Sits between the I/D cache controllers (hit reads, store hits) and the bus refill path.

Parameters:
- WAYS, 2, number of ways (power of two, ≥1)
- LINE, 128, lines per way (power of two)
- BLOCK, 8, 32-bit words per line (power of two, ≥2)
- Local parameters:
  - IW = $clog2(LINE)
  - OW = $clog2(BLOCK)
  - WW = max(1, $clog2(WAYS))

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- rd_en  in  1  read request, all ways at rd_index
- rd_index  in  IW  read line index
- rd_valid  out  1  rdata valid, exactly one cycle after an accepted rd_en
- rdata  out  WAYS*32*BLOCK  way w occupies bits [w*32*BLOCK +: 32*BLOCK]
- st_en  in  1  store-hit write request
- st_ready  out  1  store accepted when st_en && st_ready
- st_way  in  WW  target way
- st_index  in  IW  target line index
- st_offset  in  OW  target word within the line
- st_wstrb  in  4  byte enables
- st_wdata  in  32  store data
- rf_start  in  1  begin refill; sampled only in IDLE
- rf_way  in  WW  refill target way
- rf_index  in  IW  refill target line index
- rf_offset  in  OW  word offset of the first (critical) beat
- rf_valid  in  1  refill beat valid
- rf_ready  out  1  beat accepted when rf_valid && rf_ready
- rf_data  in  32  refill beat data
- rf_last  in  1  bus last flag; used only for checking
- rf_done  out  1  one-cycle pulse in the commit cycle
- rf_err  out  1  one-cycle pulse in the commit cycle if rf_last was inconsistent
- busy  out  1  refill engine not IDLE

Behaviour:
- Reset values:
  - rd_valid=0, rf_ready=0, rf_done=0, rf_err=0, busy=0
  - st_ready=1
  - FSM=IDLE, beat counter=0, err flag=0
  - rdata unspecified until first read.
- Array contents are never reset. Storage is inferred RAM: WAYS×LINE×BLOCK×32 bits, byte-write, read-first.
- Read path:
  - Read is accepted in every state.
  - rdata and rd_valid are registered: 1-cycle latency.
  - rdata holds its value while rd_en=0; rd_valid=0 in that case.
- Read-first rule: a read of the same index in the same cycle as a store or commit returns the pre-write data. The new data is visible on the next read.
- Store path:
  - st_ready = (state==IDLE).
  - An accepted store writes the enabled bytes of word st_offset in way st_way, line st_index. All other bytes are unchanged.
  - st_wstrb=0 is legal and performs no write.
- FSM:
  - IDLE: on rf_start, latch way, index and offset; counter=0; next state FILL. rf_start in the same cycle as st_en: the store is accepted (st_ready=1 in IDLE), then FILL starts next cycle.
  - FILL: rf_ready=1. Each accepted beat writes buffer word (latched_offset + counter) mod BLOCK (wrap-around), then counter increments.
    - Counter reaches BLOCK-1 with a beat accepted: next state COMMIT.
    - err flag is set if rf_last=1 on any beat other than beat BLOCK-1, or rf_last=0 on beat BLOCK-1.
    - No timeout: FILL waits indefinitely for rf_valid.
  - COMMIT (one cycle): rf_ready=0. The full line buffer is written to the latched way/index with all byte enables. rf_done=1; rf_err=err flag; err flag cleared. Next state IDLE.
- busy=1 in FILL and COMMIT; st_ready=0 there.
- rf_start outside IDLE is ignored.
- Async reset mid-FILL: the buffer is discarded, no commit occurs, array is unchanged, and the FSM returns to IDLE.
- A single-way configuration (WAYS=1) ignores st_way/rf_way.

Test Plan:
1. Reset, then store way1 idx5 off3 wstrb=4'b1111 data 32'hDEADBEEF, then read idx5 → next cycle rd_valid=1; way1 word3 = DEADBEEF; way0 unchanged.
2. Partial store wstrb=4'b0101 data 32'h11223344 onto word holding 32'hAAAAAAAA → read returns 32'hAA22AA44.
3. Refill way0 idx7 rf_offset=5, beats 0x100..0x107 with rf_last on beat 8 → words 5,6,7,0,1,2,3,4 = 0x100..0x107. rf_done pulses once, exactly 8 cycles after the first beat if rf_valid is held high; rf_err=0.
4. Refill with rf_last on beat 3 → still commits after 8 beats; rf_err=1 together with rf_done.
5. Read idx7 in the COMMIT cycle → returns the old line; read on the next cycle → returns the refilled line. Store attempted during FILL → st_ready=0, no write.
6. Assert resetn=0 after 4 beats of a refill into idx9 → busy=0, rf_ready=0 immediately; later read of idx9 shows the prior contents.
